// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and helpers for the branch resolve unit: func3 encodings,
// BHT reset value, compare-flag bundle, direction decode and counter update.
package branch_resolve_unit_pkg;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   localparam logic [1:0] BHT_INIT = 2'b01;

   typedef struct packed {
      logic z;
      logic c;
      logic s;
      logic v;
   } cmp_flags_t;

   function automatic logic func3_illegal(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

   function automatic logic resolve_dir(input logic [2:0] f3, input cmp_flags_t fl);
      logic taken;
      case (f3)
         BR_BEQ:  taken = fl.z;
         BR_BNE:  taken = ~fl.z;
         BR_BLT:  taken = fl.s ^ fl.v;
         BR_BGE:  taken = ~(fl.s ^ fl.v);
         BR_BLTU: taken = ~fl.c;
         BR_BGEU: taken = fl.c;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      if (taken) nxt = (cnt == 2'b11) ? cnt : cnt + 2'b01;
      else       nxt = (cnt == 2'b00) ? cnt : cnt - 2'b01;
      return nxt;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: direct-mapped 2-bit saturating counters with a
// combinational lookup that sees a same-cycle update (write bypass).
module branch_resolve_unit_bht
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] lk_idx,
   output logic             lk_taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   logic [1:0] cnt_q [DEPTH];
   logic [1:0] upd_val;

   assign upd_val = sat_update(cnt_q[upd_idx], upd_taken);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) cnt_q[i] <= BHT_INIT;
      end else if (upd_en) begin
         cnt_q[upd_idx] <= upd_val;
      end
   end

   assign lk_taken = (upd_en && (upd_idx == lk_idx)) ? upd_val[1] : cnt_q[lk_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compare, direction/target resolve, one-deep output
// register with valid/ready, and BHT training. BR_PERF_EN adds perf counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned BHT_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lk_pc,
   output logic            lk_taken,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_func3,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_pred,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic            out_mispred,
`ifdef BR_PERF_EN
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispreds,
`endif
   output logic            out_illegal
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   logic [XLEN:0]     diff;
   cmp_flags_t        flags;
   logic              illegal;
   logic              dir;
   logic [XLEN-1:0]   target;

   always_comb begin
      // rs1 - rs2 as rs1 + ~rs2 + 1; carry out set means no borrow (rs1 >= rs2 unsigned)
      diff    = {1'b0, in_rs1} + {1'b0, ~in_rs2} + (XLEN+1)'(1);
      flags.c = diff[XLEN];
      flags.z = (diff[XLEN-1:0] == '0);
      flags.s = diff[XLEN-1];
      flags.v = (in_rs1[XLEN-1] != in_rs2[XLEN-1]) & (flags.s != in_rs1[XLEN-1]);
      illegal = func3_illegal(in_func3);
      dir     = ~illegal & resolve_dir(in_func3, flags);
      target  = dir ? (in_pc + in_imm) : (in_pc + XLEN'(4));
   end

   logic             out_valid_q;
   logic             out_taken_q;
   logic [XLEN-1:0]  out_target_q;
   logic             out_pred_q;
   logic             out_illegal_q;
   logic [IDX_W-1:0] out_idx_q;
   logic             capture;
   logic             drain;
   logic             upd_en;

   assign in_ready = ~out_valid_q | out_ready;
   assign capture  = in_valid & in_ready;
   assign drain    = out_valid_q & out_ready;
   assign upd_en   = drain & ~out_illegal_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_taken_q   <= 1'b0;
         out_target_q  <= '0;
         out_pred_q    <= 1'b0;
         out_illegal_q <= 1'b0;
         out_idx_q     <= '0;
      end else if (capture) begin
         out_valid_q   <= 1'b1;
         out_taken_q   <= dir;
         out_target_q  <= target;
         out_pred_q    <= in_pred;
         out_illegal_q <= illegal;
         out_idx_q     <= in_pc[IDX_W+1:2];
      end else if (drain) begin
         out_valid_q   <= 1'b0;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_taken   = out_taken_q;
   assign out_target  = out_target_q;
   assign out_mispred = out_taken_q ^ out_pred_q;
   assign out_illegal = out_illegal_q;

   branch_resolve_unit_bht #(
      .DEPTH (BHT_DEPTH),
      .IDX_W (IDX_W)
   ) u_bht (
      .clk       (clk),
      .rst       (rst),
      .lk_idx    (lk_pc[IDX_W+1:2]),
      .lk_taken  (lk_taken),
      .upd_en    (upd_en),
      .upd_idx   (out_idx_q),
      .upd_taken (out_taken_q)
   );

   logic unused_lk_pc;
   assign unused_lk_pc = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0]};

`ifdef BR_PERF_EN
   logic [31:0] perf_branches_q;
   logic [31:0] perf_mispreds_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_branches_q <= '0;
         perf_mispreds_q <= '0;
      end else if (upd_en) begin
         perf_branches_q <= perf_branches_q + 32'd1;
         if (out_mispred) perf_mispreds_q <= perf_mispreds_q + 32'd1;
      end
   end

   assign perf_branches = perf_branches_q;
   assign perf_mispreds = perf_mispreds_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized stream scored against a behavioural model of resolve and BHT.
module tb_branch_resolve_unit;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic        mispred;
      logic        illegal;
      logic [5:0]  idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] lk_pc = '0;
   logic        lk_taken;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_func3 = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_rs1 = '0;
   logic [31:0] in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        in_pred = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_taken;
   logic [31:0] out_target;
   logic        out_mispred;
   logic        out_illegal;
`ifdef BR_PERF_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispreds;
`endif

   int errors = 0;
   int checks = 0;
   int bht_m [64];
   int perf_br_m = 0;
   int perf_mp_m = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(
      .XLEN      (32),
      .BHT_DEPTH (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lk_pc       (lk_pc),
      .lk_taken    (lk_taken),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_func3    (in_func3),
      .in_pc       (in_pc),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_imm      (in_imm),
      .in_pred     (in_pred),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_taken   (out_taken),
      .out_target  (out_target),
      .out_mispred (out_mispred),
`ifdef BR_PERF_EN
      .perf_branches (perf_branches),
      .perf_mispreds (perf_mispreds),
`endif
      .out_illegal (out_illegal)
   );

   // Reference model: direction from plain signed/unsigned comparisons
   function automatic exp_t model_resolve(input logic [2:0] f3, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] imm, input logic pred);
      exp_t e;
      e.illegal = (f3 == 3'd2) || (f3 == 3'd3);
      case (f3)
         3'd0:    e.taken = (a == b);
         3'd1:    e.taken = (a != b);
         3'd4:    e.taken = ($signed(a) < $signed(b));
         3'd5:    e.taken = ($signed(a) >= $signed(b));
         3'd6:    e.taken = (a < b);
         3'd7:    e.taken = (a >= b);
         default: e.taken = 1'b0;
      endcase
      e.target  = e.taken ? pc + imm : pc + 32'd4;
      e.mispred = (e.taken != pred);
      e.idx     = pc[7:2];
      return e;
   endfunction

   function automatic int sat(input int c, input bit t);
      if (t) return (c >= 3) ? 3 : c + 1;
      return (c <= 0) ? 0 : c - 1;
   endfunction

   function automatic void model_update(input exp_t e);
      if (!e.illegal) begin
         bht_m[e.idx] = sat(bht_m[e.idx], e.taken);
         perf_br_m++;
         if (e.mispred) perf_mp_m++;
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) bht_m[i] = 1;
      perf_br_m = 0;
      perf_mp_m = 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic pred);
      in_valid = 1'b1;
      in_func3 = f3;
      in_pc    = pc;
      in_rs1   = a;
      in_rs2   = b;
      in_imm   = imm;
      in_pred  = pred;
   endtask

   // One full transaction: capture, check against model, drain (trains BHT)
   task automatic send_one(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic pred,
                           output exp_t obs);
      exp_t e;
      e = model_resolve(f3, pc, a, b, imm, pred);
      out_ready = 1'b1;
      drive(f3, pc, a, b, imm, pred);
      step();
      in_valid = 1'b0;
      obs.taken = out_taken; obs.target = out_target;
      obs.mispred = out_mispred; obs.illegal = out_illegal; obs.idx = e.idx;
      checks++;
      if (out_valid !== 1'b1 || {out_taken, out_target, out_mispred, out_illegal} !==
          {e.taken, e.target, e.mispred, e.illegal}) begin
         errors++;
         $display("FAIL send_one f3=%0d pc=%h: got v=%b t=%b tgt=%h m=%b i=%b want v=1 t=%b tgt=%h m=%b i=%b",
                  f3, pc, out_valid, out_taken, out_target, out_mispred, out_illegal,
                  e.taken, e.target, e.mispred, e.illegal);
      end
      step();
      model_update(e);
   endtask

   task automatic check_lk(input string name, input logic [31:0] pc, input logic want);
      lk_pc = pc;
      #1;
      checks++;
      if (lk_taken !== want) begin
         errors++;
         $display("FAIL %s: lk_taken got %b expected %b (lk_pc=%h)", name, lk_taken, want, pc);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({out_valid, out_taken, out_target, out_mispred, out_illegal} !== 36'd0) begin
         errors++;
         $display("FAIL %s: outputs got v=%b t=%b tgt=%h m=%b i=%b expected all zero",
                  name, out_valid, out_taken, out_target, out_mispred, out_illegal);
      end
   endtask

   task automatic check_bht_all_init(input string name);
      for (int i = 0; i < 64; i++) check_lk(name, 32'(i) << 2, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b0;
      repeat (2) step();
      check_idle_outputs("reset_outputs");
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      rst = 1'b0;
      model_reset();
      step();
      check_bht_all_init("reset_bht");
   endtask

   task automatic test_beq();
      exp_t o;
      send_one(3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, o);
      checks++;
      if ({o.taken, o.target, o.mispred} !== {1'b1, 32'h120, 1'b1}) begin
         errors++;
         $display("FAIL beq_directed: got t=%b tgt=%h m=%b expected t=1 tgt=00000120 m=1",
                  o.taken, o.target, o.mispred);
      end
   endtask

   task automatic test_signed_unsigned();
      exp_t o;
      send_one(3'd4, 32'h200, 32'h80000000, 32'd1, 32'h40, 1'b1, o);
      checks++;
      if (o.taken !== 1'b1 || o.target !== 32'h240) begin
         errors++;
         $display("FAIL blt_signed: got t=%b tgt=%h expected t=1 tgt=00000240", o.taken, o.target);
      end
      send_one(3'd6, 32'h200, 32'h80000000, 32'd1, 32'h40, 1'b1, o);
      checks++;
      if (o.taken !== 1'b0 || o.target !== 32'h204 || o.mispred !== 1'b1) begin
         errors++;
         $display("FAIL bltu_unsigned: got t=%b tgt=%h m=%b expected t=0 tgt=00000204 m=1",
                  o.taken, o.target, o.mispred);
      end
   endtask

   task automatic test_bht_saturate();
      exp_t o;
      logic want [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      check_lk("bht_before", 32'h40, 1'b0);
      for (int i = 0; i < 6; i++) begin
         // four taken updates, then two not-taken to confirm saturation at 11
         if (i < 4) send_one(3'd0, 32'h40, 32'd7, 32'd7, 32'h8, 1'b1, o);
         else       send_one(3'd1, 32'h40, 32'd7, 32'd7, 32'h8, 1'b0, o);
         check_lk($sformatf("bht_sat_%0d", i), 32'h40, want[i]);
      end
   endtask

   task automatic test_backpressure();
      exp_t ea, eb;
      ea = model_resolve(3'd1, 32'h300, 32'd1, 32'd2, 32'h10, 1'b0);
      eb = model_resolve(3'd7, 32'h304, 32'd3, 32'd9, 32'h10, 1'b0);
      out_ready = 1'b0;
      drive(3'd1, 32'h300, 32'd1, 32'd2, 32'h10, 1'b0);
      step();
      drive(3'd7, 32'h304, 32'd3, 32'd9, 32'h10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
             {out_taken, out_target, out_mispred, out_illegal} !==
             {ea.taken, ea.target, ea.mispred, ea.illegal}) begin
            errors++;
            $display("FAIL stall_%0d: got rdy=%b v=%b t=%b tgt=%h expected rdy=0 v=1 t=%b tgt=%h",
                     i, in_ready, out_valid, out_taken, out_target, ea.taken, ea.target);
         end
         if (i < 2) step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready: got %b expected 1", in_ready);
      end
      step();
      model_update(ea);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || {out_taken, out_target, out_mispred} !==
          {eb.taken, eb.target, eb.mispred}) begin
         errors++;
         $display("FAIL back_to_back: got v=%b t=%b tgt=%h m=%b expected v=1 t=%b tgt=%h m=%b",
                  out_valid, out_taken, out_target, out_mispred, eb.taken, eb.target, eb.mispred);
      end
      step();
      model_update(eb);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_illegal_bypass();
      exp_t o, e;
      send_one(3'd2, 32'h80, 32'd4, 32'd4, 32'h20, 1'b1, o);
      checks++;
      if (o.illegal !== 1'b1 || o.taken !== 1'b0 || o.target !== 32'h84) begin
         errors++;
         $display("FAIL illegal_op: got i=%b t=%b tgt=%h expected i=1 t=0 tgt=00000084",
                  o.illegal, o.taken, o.target);
      end
      check_lk("illegal_no_update", 32'h80, 1'b0);
      // counter still 01: a taken update shows 1 through the bypass in the same cycle
      e = model_resolve(3'd0, 32'h80, 32'd4, 32'd4, 32'h20, 1'b1);
      out_ready = 1'b0;
      drive(3'd0, 32'h80, 32'd4, 32'd4, 32'h20, 1'b1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_lk("bypass_same_cycle", 32'h80, 1'b1);
      step();
      model_update(e);
      check_lk("bypass_after", 32'h80, 1'b1);
   endtask

   task automatic test_wrap_reset();
      out_ready = 1'b0;
      drive(3'd1, 32'hFFFFFFFC, 32'd9, 32'd9, 32'h100, 1'b0);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_target !== 32'h0) begin
         errors++;
         $display("FAIL pc_wrap: got v=%b t=%b tgt=%h expected v=1 t=0 tgt=00000000",
                  out_valid, out_taken, out_target);
      end
      rst = 1'b1;
      #1;
      check_idle_outputs("async_reset");
      model_reset();
      step();
      rst = 1'b0;
      check_bht_all_init("reset_bht_again");
      begin
         exp_t o;
         send_one(3'd1, 32'h100, 32'd1, 32'd1, 32'h4, 1'b0, o);
      end
      check_lk("post_reset_nt", 32'h100, 1'b0);
   endtask

   task automatic test_random();
      exp_t held, e;
      logic m_valid;
      int   want;
      m_valid = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         lk_pc     = {$urandom_range(0, 255), 2'b00};
         in_valid  = $urandom_range(0, 1);
         in_func3  = 3'($urandom_range(0, 7));
         in_pc     = {$urandom_range(0, 255), 2'b00};
         if ($urandom_range(0, 15) == 0) in_pc = 32'hFFFFFFFC;
         in_rs1    = $urandom;
         in_rs2    = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
         in_imm    = $urandom;
         in_pred   = $urandom_range(0, 1);
         #1;
         checks++;
         if (in_ready !== (!m_valid || out_ready) || out_valid !== m_valid) begin
            errors++;
            $display("FAIL rnd_handshake cyc=%0d: got rdy=%b v=%b expected rdy=%b v=%b",
                     cyc, in_ready, out_valid, !m_valid || out_ready, m_valid);
         end
         if (m_valid) begin
            checks++;
            if ({out_taken, out_target, out_mispred, out_illegal} !==
                {held.taken, held.target, held.mispred, held.illegal}) begin
               errors++;
               $display("FAIL rnd_result cyc=%0d: got t=%b tgt=%h m=%b i=%b expected t=%b tgt=%h m=%b i=%b",
                        cyc, out_taken, out_target, out_mispred, out_illegal,
                        held.taken, held.target, held.mispred, held.illegal);
            end
         end
         want = bht_m[lk_pc[7:2]];
         if (m_valid && out_ready && !held.illegal && held.idx == lk_pc[7:2])
            want = sat(want, held.taken);
         checks++;
         if (lk_taken !== (want >= 2)) begin
            errors++;
            $display("FAIL rnd_lookup cyc=%0d: lk_taken got %b expected %b", cyc, lk_taken,
                     want >= 2);
         end
         e = model_resolve(in_func3, in_pc, in_rs1, in_rs2, in_imm, in_pred);
         if (m_valid && out_ready) model_update(held);
         if (in_valid && (!m_valid || out_ready)) begin
            held    = e;
            m_valid = 1'b1;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_perf();
`ifdef BR_PERF_EN
      checks++;
      if (perf_branches !== 32'(perf_br_m) || perf_mispreds !== 32'(perf_mp_m)) begin
         errors++;
         $display("FAIL perf_counters: got br=%0d mp=%0d expected br=%0d mp=%0d",
                  perf_branches, perf_mispreds, perf_br_m, perf_mp_m);
      end
`endif
   endtask

   initial begin
      model_reset();
      test_reset();
      test_beq();
      test_signed_unsigned();
      test_bht_saturate();
      test_backpressure();
      test_illegal_bypass();
      test_perf();
      test_wrap_reset();
      test_random();
      out_ready = 1'b1;
      step();
      step();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
